// File: rtl/lab1_sys_button_ctrl_if.sv
// rtl/lab1_sys_button_ctrl_if.sv - Avalon-MM register bus bundle for the button controller
//
// Signals:
//   address[1:0]    register select
//   chipselect      bus cycle qualifier
//   read_n          active-low read strobe
//   write_n         active-low write strobe
//   writedata[31:0] write data
//   readdata[31:0]  registered read data (driven by the slave)
// Modports: master (bus initiator), slave (button controller).
interface lab1_sys_button_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output read_n,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  read_n,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/lab1_sys_button_ctrl.sv
// rtl/lab1_sys_button_ctrl.sv - debounced push-button controller with event FIFO and IRQ
//
// Each active-low button input is synchronised, debounced and turned into
// press (and optionally release) events that are queued in a small FIFO and
// read through an Avalon-MM slave register window.
//
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   avs      Avalon-MM slave (address, chipselect, read_n, write_n, writedata, readdata)
//   in_port  raw button levels, active-low, asynchronous to clk
//   irq      level interrupt = IRQ_MASK & FIFO non-empty
//
// Registers: 0 STATUS (count[4:0], empty[8], full[9], OVERFLOW[10], write bit10 clears),
//            1 EVENT (bit31 valid, bit8 kind, bits[3:0] index; read pops),
//            2 IRQ_MASK (bit0 RW), 3 LEVEL (debounced levels).
//
// Build option: define BUTTON_CTRL_RELEASE_EVT_EN to queue release events as
// well as presses; otherwise releases only update LEVEL.
module lab1_sys_button_ctrl #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    lab1_sys_button_ctrl_if.slave avs,
    input  logic [N_BTN-1:0]      in_port,
    output logic                  irq
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FIFO_FULLV = FCNT_W'(FIFO_DEPTH);

    // synchroniser and debounce state
    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] flip;
    logic [N_BTN-1:0] press_evt;
    logic [N_BTN-1:0] new_evt;

    // pending events and scheduler
    logic [N_BTN-1:0] pend_q, pend_d;
    logic [N_BTN-1:0] sel_onehot;
    logic             sel_valid;
    logic [3:0]       sel_idx;
    logic             ev_kind;

    // event FIFO
    logic [4:0]        fifo_mem [FIFO_DEPTH];
    logic [4:0]        head;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] count_q, count_d;
    logic              fifo_empty, fifo_full;
    logic              push, pop, drop;

    // register file
    logic        mask_q, mask_d;
    logic        ovf_q, ovf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rd_strobe, wr_strobe;
    logic        unused_wdata;

    assign unused_wdata = ^{avs.writedata[31:11], avs.writedata[9:1]};

    // ---------------- synchroniser ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    // ---------------- debounce ----------------
    // The counter measures how long the synced level has disagreed with the
    // accepted level; any agreement restarts the measurement.
    always_comb begin
        deb_d = deb_q;
        flip  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    flip[i]  = 1'b1;
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q <= '1;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // A flip away from the released level (1) is a press.
    assign press_evt = flip & deb_q;

    // ---------------- pending events ----------------
    // Lowest set bit of pend_q is the button serviced this cycle.
    assign sel_onehot = pend_q & (~pend_q + N_BTN'(1));
    assign sel_valid  = |pend_q;

    always_comb begin
        sel_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_q[i]) sel_idx = 4'(i);
        end
    end

`ifdef BUTTON_CTRL_RELEASE_EVT_EN
    logic [N_BTN-1:0] kind_q, kind_d;

    assign new_evt = flip;
    assign ev_kind = |(kind_q & sel_onehot);
    // A fresh event on a button overwrites the kind of any older pending one.
    assign kind_d  = (kind_q & ~new_evt) | press_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) kind_q <= '0;
        else          kind_q <= kind_d;
    end
`else
    assign new_evt = press_evt;
    assign ev_kind = 1'b1;
`endif

    // An event arriving on the button being scheduled stays pending.
    assign pend_d = (pend_q & ~sel_onehot) | new_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

    // ---------------- FIFO control ----------------
    assign rd_strobe  = avs.chipselect & ~avs.read_n;
    assign wr_strobe  = avs.chipselect & ~avs.write_n;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FIFO_FULLV);
    assign head       = fifo_mem[rd_ptr_q];

    assign pop  = rd_strobe && (avs.address == 2'd1) && !fifo_empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push = sel_valid && (!fifo_full || pop);
    assign drop = sel_valid && fifo_full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {ev_kind, sel_idx};
    end

    // ---------------- registers ----------------
    always_comb begin
        mask_d = mask_q;
        ovf_d  = ovf_q;
        if (wr_strobe && avs.address == 2'd2) mask_d = avs.writedata[0];
        if (wr_strobe && avs.address == 2'd0 && avs.writedata[10]) ovf_d = 1'b0;
        // A drop in the clearing cycle must not be lost.
        if (drop) ovf_d = 1'b1;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_strobe) begin
            rdata_d = '0;
            case (avs.address)
                2'd0: begin
                    rdata_d[FCNT_W-1:0] = count_q;
                    rdata_d[8]          = fifo_empty;
                    rdata_d[9]          = fifo_full;
                    rdata_d[10]         = ovf_q;
                end
                2'd1: begin
                    if (!fifo_empty) begin
                        rdata_d[31]  = 1'b1;
                        rdata_d[8]   = head[4];
                        rdata_d[3:0] = head[3:0];
                    end
                end
                2'd2:    rdata_d[0]         = mask_q;
                default: rdata_d[N_BTN-1:0] = deb_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mask_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mask_q   <= mask_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign avs.readdata = rdata_q;
    assign irq          = mask_q & ~fifo_empty;

endmodule
